// File: rtl/packer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : packer_pkg
// Description : Shared constants and helpers for the byte packer slice.
//               IN_WIDTH_DEF / RATIO_DEF  - default lane width and pack ratio
//               OUT_WIDTH                 - packed word width for the defaults
//               CNT_WIDTH                 - lane counter width for the defaults
//               keep_mask()               - lane count -> contiguous keep mask
// Revision    : 1.0 - initial release
// ============================================================================
package packer_pkg;

  localparam int IN_WIDTH_DEF = 8;
  localparam int RATIO_DEF    = 4;
  localparam int OUT_WIDTH    = IN_WIDTH_DEF * RATIO_DEF;
  localparam int CNT_WIDTH    = $clog2(RATIO_DEF);

  // Largest legal ratio is 8, so an 8-bit mask covers every configuration;
  // callers truncate to RATIO lanes. n lanes valid -> n ones from bit 0.
  function automatic logic [7:0] keep_mask(input logic [3:0] n);
    logic [8:0] t;
    t = (9'd1 << n) - 9'd1;
    return t[7:0];
  endfunction

endpackage : packer_pkg
`default_nettype wire

// File: rtl/packer_idle_timer.sv
`default_nettype none
// ============================================================================
// Module      : packer_idle_timer
// Description : Saturating idle counter. Counts enabled cycles, holds at
//               TIMEOUT, and reports expired while saturated. TIMEOUT=0
//               disables the timer (expired is constant low).
// Ports       : clk     - clock
//               rst     - synchronous active-high reset
//               clear   - restart counting from zero (wins over enable)
//               enable  - count this cycle
//               expired - counter has reached TIMEOUT
// Revision    : 1.0 - initial release
// ============================================================================
module packer_idle_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_disabled
      assign expired = 1'b0;
    end else begin : g_enabled
      localparam int TW = $clog2(TIMEOUT + 1);
      logic [TW-1:0] timer_q;

      always_ff @(posedge clk) begin
        if (rst || clear) begin
          timer_q <= '0;
        end else if (enable && (timer_q != TW'(TIMEOUT))) begin
          timer_q <= timer_q + 1'b1;
        end
      end

      // Stays high while saturated so an expiry that lands while the output
      // register is stalled is still honoured once it frees.
      assign expired = (timer_q == TW'(TIMEOUT));
    end
  endgenerate

endmodule : packer_idle_timer
`default_nettype wire

// File: rtl/byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : byte_packer
// Description : Packs RATIO input beats of IN_WIDTH bits into one output word,
//               first beat in the LSBs. Partial words are emitted on flush or
//               after TIMEOUT idle cycles, with keep_out marking valid lanes.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               valid_in/ready_in   - input beat handshake, data_in payload
//               flush               - emit the current partial word
//               valid_out/ready_out - output word handshake
//               data_out, keep_out  - packed word and per-lane valid mask
// Revision    : 1.0 - initial release
// ============================================================================
module byte_packer
  import packer_pkg::*;
#(
  parameter int IN_WIDTH = IN_WIDTH_DEF,
  parameter int RATIO    = RATIO_DEF,
  parameter int TIMEOUT  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_in,
  input  logic [IN_WIDTH-1:0]       data_in,
  output logic                      ready_in,
  input  logic                      flush,
  output logic                      valid_out,
  output logic [IN_WIDTH*RATIO-1:0] data_out,
  output logic [RATIO-1:0]          keep_out,
  input  logic                      ready_out
);

  localparam int OUT_W = IN_WIDTH * RATIO;
  localparam int CW    = $clog2(RATIO);

  logic [CW-1:0]    count_q, count_d;
  logic             valid_q, valid_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic [RATIO-1:0] keep_q, keep_d;
  logic             pend_q, pend_d;

  logic             w_accept;
  logic             w_last_lane;
  logic             w_full;
  logic             w_out_xfer;
  logic             w_out_free;
  logic [CW:0]      w_cnt_eff;
  logic             w_expired;
  logic             w_flush_req;
  logic             w_do_flush;
  logic             w_load;
  logic [RATIO-1:0] w_keep;
  logic [OUT_W-1:0] w_word;

  assign w_last_lane = (count_q == CW'(RATIO - 1));
  // Only stall: the final lane is due while the held word cannot leave.
  assign ready_in    = !(w_last_lane && valid_q && !ready_out);
  assign w_accept    = valid_in && ready_in;
  assign w_full      = w_accept && w_last_lane;
  assign w_out_xfer  = valid_q && ready_out;
  assign w_out_free  = !valid_q || ready_out;

  // Lanes occupied once this cycle's beat (if any) is counted.
  assign w_cnt_eff   = {1'b0, count_q} + {{CW{1'b0}}, w_accept};

  assign w_flush_req = flush || pend_q || w_expired;
  // A full word already empties the accumulator, so flush has nothing extra.
  assign w_do_flush  = w_flush_req && !w_full && (w_cnt_eff != '0) && w_out_free;
  assign w_load      = w_full || w_do_flush;

  assign w_keep      = RATIO'(keep_mask(4'(w_cnt_eff)));

  // Candidate output word: stored lanes, the current beat in lane count_q,
  // and zeros in every lane beyond the valid count.
  generate
    for (genvar k = 0; k < RATIO; k++) begin : g_lane
      logic [IN_WIDTH-1:0] w_acc_lane;

      if (k < RATIO - 1) begin : g_acc
        logic [IN_WIDTH-1:0] lane_q;

        always_ff @(posedge clk) begin
          if (rst) begin
            lane_q <= '0;
          end else if (w_accept && !w_full && (count_q == CW'(k))) begin
            lane_q <= data_in;
          end
        end

        assign w_acc_lane = lane_q;
      end else begin : g_top
        // The last lane is never stored; it comes straight from data_in.
        assign w_acc_lane = '0;
      end

      assign w_word[k*IN_WIDTH +: IN_WIDTH] =
        !w_keep[k]                           ? '0      :
        (w_accept && (count_q == CW'(k)))    ? data_in :
                                               w_acc_lane;
    end
  endgenerate

  packer_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_accept || w_load),
    .enable  ((count_q != '0) && !w_accept),
    .expired (w_expired)
  );

  always_comb begin
    count_d = count_q;
    if (w_load) begin
      count_d = '0;
    end else if (w_accept) begin
      count_d = count_q + 1'b1;
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    keep_d  = keep_q;
    if (w_load) begin
      valid_d = 1'b1;
      data_d  = w_word;
      keep_d  = w_keep;
    end else if (w_out_xfer) begin
      valid_d = 1'b0;
    end
  end

  // Remember a flush that arrives while the output register is stalled.
  assign pend_d = !w_load &&
                  (pend_q || (flush && (w_cnt_eff != '0) && !w_out_free));

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      pend_q  <= pend_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign keep_out  = keep_q;

endmodule : byte_packer
`default_nettype wire

// File: tb/tb_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_byte_packer
// Description : Self-checking bench for byte_packer (default parameters).
//               Expected words are queued as stimulus is driven and compared
//               by a monitor whenever a word transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_packer;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [7:0]  data_in;
  logic        ready_in;
  logic        flush;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        ready_out;

  int errors;
  int checks;

  logic [35:0] exp_q[$];   // {keep, data}

  byte_packer dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_in  (ready_in),
    .flush     (flush),
    .valid_out (valid_out),
    .data_out  (data_out),
    .keep_out  (keep_out),
    .ready_out (ready_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: every transferring word must match the oldest expectation.
  always @(negedge clk) begin
    logic [35:0] e;
    if (!rst && valid_out && ready_out) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got data 0x%08h keep 0x%h, required none", data_out, keep_out);
      end else begin
        e = exp_q.pop_front();
        chk("word_data", data_out, e[31:0]);
        chk("word_keep", {28'd0, keep_out}, {28'd0, e[35:32]});
      end
    end
  end

  // Sticky flags for the watch windows of the directed sequences.
  logic watch_rdy, rdy_dropped;
  logic watch_vld, vld_seen;
  always @(negedge clk) begin
    if (watch_rdy && !ready_in) rdy_dropped = 1'b1;
    if (watch_vld && valid_out) vld_seen = 1'b1;
  end

  task automatic send(input logic [7:0] b);
    int t;
    valid_in = 1'b1;
    data_in  = b;
    t = 0;
    @(negedge clk);
    while (!ready_in && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!ready_in) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: ready_in got 0 required 1");
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 60) begin
      @(posedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  typedef struct {
    int          n;
    logic [31:0] beats;
    logic        fl;
    logic [31:0] exp_d;
    logic [3:0]  exp_k;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int first;
    errors = 0; checks = 0;
    rst = 1'b1; valid_in = 1'b0; data_in = '0; flush = 1'b0; ready_out = 1'b1;
    watch_rdy = 1'b0; rdy_dropped = 1'b0; watch_vld = 1'b0; vld_seen = 1'b0;

    tbl[0] = '{4, 32'h44332211, 1'b0, 32'h44332211, 4'hF};
    tbl[1] = '{2, 32'h0000BBAA, 1'b1, 32'h0000BBAA, 4'h3};
    tbl[2] = '{3, 32'h00030201, 1'b1, 32'h00030201, 4'h7};
    tbl[3] = '{1, 32'h00000077, 1'b1, 32'h00000077, 4'h1};
    tbl[4] = '{4, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 4'hF};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_out", {31'd0, valid_out}, 0);
    chk("rst_keep_out", {28'd0, keep_out}, 0);
    chk("rst_data_out", data_out, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_in_after_rst", {31'd0, ready_in}, 1);

    // Table-driven words, ready_out held high
    for (int i = 0; i < 5; i++) begin
      vec_t v;
      logic [31:0] bb;
      v = tbl[i];
      bb = v.beats;
      exp_q.push_back({v.exp_k, v.exp_d});
      for (int k = 0; k < v.n; k++) send(bb[k*8 +: 8]);
      if (v.n == 4) chk("full_word_latency", {31'd0, valid_out}, 1);
      if (v.fl) pulse_flush();
      drain();
    end

    // 8 bytes back-to-back: two words, no stall
    exp_q.push_back({4'hF, 32'h44332211});
    exp_q.push_back({4'hF, 32'h88776655});
    watch_rdy = 1'b1; rdy_dropped = 1'b0;
    for (int k = 1; k <= 8; k++) send(8'(k * 8'h11));
    watch_rdy = 1'b0;
    chk("b2b_ready_never_dropped", {31'd0, rdy_dropped}, 0);
    drain();

    // Output stalled with a full word held, then 4 more bytes
    ready_out = 1'b0;
    exp_q.push_back({4'hF, 32'h44332211});
    exp_q.push_back({4'hF, 32'h88776655});
    for (int k = 1; k <= 4; k++) send(8'(k * 8'h11));
    chk("stall_ready_after_full", {31'd0, ready_in}, 1);
    send(8'h55); send(8'h66); send(8'h77);
    chk("stall_ready_in_low", {31'd0, ready_in}, 0);
    valid_in = 1'b1; data_in = 8'h88;
    repeat (3) @(posedge clk);
    #1;
    chk("stall_ready_in_still_low", {31'd0, ready_in}, 0);
    chk("stall_valid_held", {31'd0, valid_out}, 1);
    chk("stall_data_held", data_out, 32'h44332211);
    ready_out = 1'b1;
    send(8'h88);
    drain();

    // Flush while stalled is remembered and executed once the register frees
    ready_out = 1'b0;
    exp_q.push_back({4'hF, 32'hC4C3C2C1});
    exp_q.push_back({4'h3, 32'h0000D2D1});
    send(8'hC1); send(8'hC2); send(8'hC3); send(8'hC4);
    send(8'hD1); send(8'hD2);
    pulse_flush();
    repeat (2) @(posedge clk);
    #1;
    chk("pend_held_data", data_out, 32'hC4C3C2C1);
    ready_out = 1'b1;
    drain();

    // Flush with nothing accumulated emits nothing
    watch_vld = 1'b1; vld_seen = 1'b0;
    pulse_flush();
    repeat (5) @(posedge clk);
    #1;
    watch_vld = 1'b0;
    chk("flush_empty_no_word", {31'd0, vld_seen}, 0);

    // Idle timeout auto-flush of a single byte
    exp_q.push_back({4'h1, 32'h0000005A});
    send(8'h5A);
    first = 0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (valid_out && first == 0) first = i;
    end
    chk("idle_timeout_window", {31'd0, (first >= 17 && first <= 18)}, 1);
    drain();

    // Reset mid-word discards the partial word
    send(8'hE1); send(8'hE2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_ready_in", {31'd0, ready_in}, 1);
    watch_vld = 1'b1; vld_seen = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    watch_vld = 1'b0;
    chk("midrst_no_word", {31'd0, vld_seen}, 0);
    exp_q.push_back({4'hF, 32'h04030201});
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

endmodule : tb_byte_packer
`default_nettype wire

// File: doc/byte_packer.md
BYTE_PACKER -- requirements
Module: byte_packer

Interface
REQ-001 Parameter IN_WIDTH, default 8: width of one input byte lane; it SHALL match the upstream fifo_sync DATA_WIDTH.
REQ-002 Parameter RATIO, default 4: input beats packed per output word; legal values are 2, 4 and 8.
REQ-003 Parameter TIMEOUT, default 16: number of idle cycles before an automatic flush of a partial word; 0 disables the auto-flush.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk  in  1  clock; all logic SHALL be on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 valid_in  in  1  input beat valid; driven by the fifo_sync output side.
REQ-008 data_in  in  IN_WIDTH  input beat.
REQ-009 ready_in  out  1  block can accept a beat; wired to the FIFO's ready_out.
REQ-010 flush  in  1  request to emit the current partial word.
REQ-011 valid_out  out  1  output word valid.
REQ-012 data_out  out  IN_WIDTH*RATIO  packed word; beat k SHALL occupy bits [k*IN_WIDTH +: IN_WIDTH] (first beat in the LSBs).
REQ-013 keep_out  out  RATIO  per-lane valid mask; always a contiguous run of ones starting at bit 0.
REQ-014 ready_out  in  1  downstream accepts the output word.

Function
REQ-015 A beat SHALL transfer when valid_in && ready_in; an output word SHALL transfer when valid_out && ready_out.
REQ-016 Accumulator: register of RATIO-1 lanes plus a count (0..RATIO-1); an accepted beat SHALL be written to lane count.
REQ-017 Full word: a beat accepted when count==RATIO-1 SHALL load the accumulator lanes plus that beat into the output register on the same edge; keep_out = all ones; count returns to 0.
REQ-018 Latency: the last beat of a word accepted on edge N SHALL make valid_out high in the cycle following edge N.
REQ-019 ready_in = !(count==RATIO-1 && valid_out && !ready_out).
  - This is a combinational path from ready_out; no other stall condition exists.
  - It gives full throughput of 1 beat/cycle while ready_out is held high.
REQ-020 Output register: once valid_out is high, data_out and keep_out SHALL hold stable until the word transfers.
  - valid_out SHALL NOT drop without a transfer.
REQ-021 Flush: when flush is high, count (including any beat accepted that cycle) is >0, and the output register is empty or draining, the partial word SHALL load into the output register.
  - keep_out has count ones; unused lanes are 0; count returns to 0.
REQ-022 Flush while the output register is stalled SHALL be remembered as pending and executed on the first cycle the register frees.
REQ-023 Flush with count==0 and no beat accepted SHALL be a no-op; no empty word is ever emitted.
REQ-024 Flush coinciding with a full-word completion SHALL emit that full word only; no extra empty word.
REQ-025 Idle timer:
  - counts cycles with count>0 and no beat accepted;
  - clears on any accepted beat or emitted word;
  - when it reaches TIMEOUT it SHALL act as flush.
REQ-026 Status: the state space is {EMPTY, ACCUM(count), HOLD}; HOLD (valid_out high) is orthogonal to count.

Reset
REQ-027 On rst, on a rising edge, the block SHALL set: count=0, valid_out=0, keep_out=0, data_out=0, pending flush=0, idle timer=0.
REQ-028 ready_in SHALL be 1 in the cycle after reset is released.
REQ-029 Reset mid-word SHALL discard partial and held data; no word is emitted after reset.

Structure
REQ-030 Package packer_pkg SHALL hold:
  - defaults for IN_WIDTH and RATIO;
  - the localparam OUT_WIDTH;
  - the count width, $clog2(RATIO);
  - a function mapping count to the keep mask.
REQ-031 The idle timer SHALL be a separate sub-module, packer_idle_timer, with ports clk, rst, clear, enable and expired.
REQ-032 The RTL SHALL be synthesizable and contain no latches.

Verification
REQ-033 The bench SHALL cover these directed scenarios (default parameters):
  - Bytes 0x11,0x22,0x33,0x44 on consecutive cycles with ready_out=1 -> data_out=0x44332211, keep_out=0xF, valid_out high one cycle after the 4th byte.
  - 8 bytes back-to-back with ready_out=1 -> 2 words, ready_in never drops.
  - ready_out=0 with a full word held, then 4 more bytes -> ready_in=0 after the 3rd new byte; raising ready_out drains the first word, then the second word is 0x88776655.
  - Bytes 0xAA,0xBB then flush -> keep_out=0x3, data_out=0x0000BBAA.
  - Flush with count==0 -> no valid_out.
  - One byte 0x5A then idle -> word keep_out=0x1, data_out=0x5A, emitted after 16 idle cycles.
  - Reset asserted after 2 bytes -> no output word; the next 4 bytes form a clean word.
